// File: rtl/cursor_pos_sched.sv
// Cursor position scheduler: arbitrates Bluetooth/button moves into a shadow position and
// commits it to the VGA coordinates only at frame start. Define CURSOR_SCHED_DEADZONE_EN to drop |delta| <= 1.
module cursor_pos_sched #(
  parameter int unsigned X_MIN    = 3,
  parameter int unsigned X_MAX    = 636,
  parameter int unsigned Y_MIN    = 3,
  parameter int unsigned Y_MAX    = 476,
  parameter int unsigned X_CENTER = 320,
  parameter int unsigned Y_CENTER = 240,
  localparam int unsigned COORD_W = 10,
  localparam int unsigned DELTA_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_bt,
  input  logic [DELTA_W-1:0] bt_dx,
  input  logic [DELTA_W-1:0] bt_dy,
  input  logic               req_btn,
  input  logic [DELTA_W-1:0] btn_dx,
  input  logic [DELTA_W-1:0] btn_dy,
  input  logic               frame_start,
  output logic               gnt_bt,
  output logic               gnt_btn,
  output logic [COORD_W-1:0] x_coordinate,
  output logic [COORD_W-1:0] y_coordinate,
  output logic               pending
);

  localparam int unsigned SUM_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_COMMIT
  } state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] shadow_x_q, shadow_x_d;
  logic [COORD_W-1:0] shadow_y_q, shadow_y_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [DELTA_W-1:0] dx_q, dx_d;
  logic [DELTA_W-1:0] dy_q, dy_d;
  logic               dirty_q, dirty_d;
  logic               frame_q, frame_d;
  logic               prefer_bt_q, prefer_bt_d;

  logic [DELTA_W-1:0] eff_dx_c, eff_dy_c;
  logic               apply_dirty_c;
  logic [COORD_W-1:0] next_x_c, next_y_c;

  // Saturating add of a signed delta onto an unsigned coordinate, evaluated wide enough to never wrap.
  function automatic logic [COORD_W-1:0] clamp_add(
    input logic [COORD_W-1:0] base,
    input logic [DELTA_W-1:0] delta,
    input int unsigned        lo,
    input int unsigned        hi
  );
    logic signed [SUM_W-1:0] sum;
    sum = $signed({{(SUM_W-COORD_W){1'b0}}, base})
        + $signed({{(SUM_W-DELTA_W){delta[DELTA_W-1]}}, delta});
    if (sum < $signed(SUM_W'(lo))) begin
      clamp_add = COORD_W'(lo);
    end else if (sum > $signed(SUM_W'(hi))) begin
      clamp_add = COORD_W'(hi);
    end else begin
      clamp_add = COORD_W'(sum);
    end
  endfunction

`ifdef CURSOR_SCHED_DEADZONE_EN
  function automatic logic in_deadzone(input logic [DELTA_W-1:0] d);
    return (d == DELTA_W'(0)) || (d == DELTA_W'(1)) || (d == {DELTA_W{1'b1}});
  endfunction

  // Jitter filter: +-1 counts treated as no motion; an all-zero move leaves the position clean.
  always_comb begin
    eff_dx_c      = in_deadzone(dx_q) ? '0 : dx_q;
    eff_dy_c      = in_deadzone(dy_q) ? '0 : dy_q;
    apply_dirty_c = (eff_dx_c != '0) || (eff_dy_c != '0);
  end
`else
  always_comb begin
    eff_dx_c      = dx_q;
    eff_dy_c      = dy_q;
    apply_dirty_c = 1'b1;
  end
`endif

  always_comb begin
    next_x_c = clamp_add(shadow_x_q, eff_dx_c, X_MIN, X_MAX);
    next_y_c = clamp_add(shadow_y_q, eff_dy_c, Y_MIN, Y_MAX);
  end

  // Next-state, arbitration and datapath updates.
  always_comb begin
    state_d     = state_q;
    shadow_x_d  = shadow_x_q;
    shadow_y_d  = shadow_y_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    dirty_d     = dirty_q;
    frame_d     = frame_q;
    prefer_bt_d = prefer_bt_q;
    gnt_bt      = 1'b0;
    gnt_btn     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_start || frame_q) begin
          state_d = ST_COMMIT;
        end else if (req_bt && (!req_btn || prefer_bt_q)) begin
          gnt_bt      = 1'b1;
          dx_d        = bt_dx;
          dy_d        = bt_dy;
          prefer_bt_d = 1'b0;
          state_d     = ST_APPLY;
        end else if (req_btn) begin
          gnt_btn     = 1'b1;
          dx_d        = btn_dx;
          dy_d        = btn_dy;
          prefer_bt_d = 1'b1;
          state_d     = ST_APPLY;
        end
      end

      ST_APPLY: begin
        shadow_x_d = next_x_c;
        shadow_y_d = next_y_c;
        if (apply_dirty_c) begin
          dirty_d = 1'b1;
        end
        frame_d = frame_q | frame_start;
        state_d = ST_IDLE;
      end

      ST_COMMIT: begin
        if (dirty_q) begin
          x_d     = shadow_x_q;
          y_d     = shadow_y_q;
          dirty_d = 1'b0;
        end
        // A pulse landing on the commit cycle belongs to the next frame, so it re-arms the flag.
        frame_d = frame_start;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shadow_x_q  <= COORD_W'(X_CENTER);
      shadow_y_q  <= COORD_W'(Y_CENTER);
      x_q         <= COORD_W'(X_CENTER);
      y_q         <= COORD_W'(Y_CENTER);
      dx_q        <= '0;
      dy_q        <= '0;
      dirty_q     <= 1'b0;
      frame_q     <= 1'b0;
      prefer_bt_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      shadow_x_q  <= shadow_x_d;
      shadow_y_q  <= shadow_y_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      dirty_q     <= dirty_d;
      frame_q     <= frame_d;
      prefer_bt_q <= prefer_bt_d;
    end
  end

  assign x_coordinate = x_q;
  assign y_coordinate = y_q;
  assign pending      = dirty_q;

endmodule

// File: tb/tb_cursor_pos_sched.sv
// Bench for cursor_pos_sched: directed vector table, hand-written corner sequences and a
// randomized move/commit stream checked against a position-level reference model.
module tb_cursor_pos_sched;

  logic       clk;
  logic       reset;
  logic       req_bt, req_btn, frame_start;
  logic [7:0] bt_dx, bt_dy, btn_dx, btn_dy;
  logic       gnt_bt, gnt_btn, pending;
  logic [9:0] x_coordinate, y_coordinate;

  int checks = 0;
  int errors = 0;

  // Reference model: shadow position, committed position, dirty flag.
  int mx, my, cx, cy, md;

  cursor_pos_sched dut (
    .clk          (clk),
    .reset        (reset),
    .req_bt       (req_bt),
    .bt_dx        (bt_dx),
    .bt_dy        (bt_dy),
    .req_btn      (req_btn),
    .btn_dx       (btn_dx),
    .btn_dy       (btn_dy),
    .frame_start  (frame_start),
    .gnt_bt       (gnt_bt),
    .gnt_btn      (gnt_btn),
    .x_coordinate (x_coordinate),
    .y_coordinate (y_coordinate),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grants must be mutually exclusive in every cycle.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (gnt_bt && gnt_btn) begin
        errors++;
        $display("FAIL gnt_exclusive got bt=%0d btn=%0d expected not both", gnt_bt, gnt_btn);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int filt(input int d);
`ifdef CURSOR_SCHED_DEADZONE_EN
    return (d >= -1 && d <= 1) ? 0 : d;
`else
    return d;
`endif
  endfunction

  function automatic int sx8(input logic [7:0] b);
    return int'($signed(b));
  endfunction

  task automatic model_reset();
    mx = 320; my = 240; cx = 320; cy = 240; md = 0;
  endtask

  task automatic model_move(input int dx, input int dy);
    int fx, fy;
    fx = filt(dx);
    fy = filt(dy);
    mx = clampi(mx + fx, 3, 636);
    my = clampi(my + fy, 3, 476);
`ifdef CURSOR_SCHED_DEADZONE_EN
    if (fx != 0 || fy != 0) md = 1;
`else
    md = 1;
`endif
  endtask

  task automatic model_frame();
    if (md != 0) begin
      cx = mx; cy = my; md = 0;
    end
  endtask

  // All tasks start and end at the drive point, 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b0;
    req_bt = 1'b0; req_btn = 1'b0; frame_start = 1'b0;
    bt_dx = '0; bt_dy = '0; btn_dx = '0; btn_dy = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic wait_grant(input bit use_btn, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (use_btn ? gnt_btn : gnt_bt) got = 1'b1;
      @(posedge clk);
      #1;
    end
    check("grant_seen", int'(got), 1);
  endtask

  task automatic move(input bit use_btn, input int dx, input int dy);
    bit got;
    if (use_btn) begin
      req_btn = 1'b1; btn_dx = 8'(dx); btn_dy = 8'(dy);
    end else begin
      req_bt = 1'b1; bt_dx = 8'(dx); bt_dy = 8'(dy);
    end
    wait_grant(use_btn, got);
    req_bt = 1'b0;
    req_btn = 1'b0;
    @(negedge clk);
    check("gnt_one_cycle", int'(gnt_bt | gnt_btn), 0);
    @(posedge clk);
    #1;
    model_move(dx, dy);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(posedge clk);
    #1;
    model_frame();
  endtask

  task automatic check_out(input string tag, input int ex, input int ey, input int ep);
    @(negedge clk);
    check({tag, "_x"}, int'(x_coordinate), ex);
    check({tag, "_y"}, int'(y_coordinate), ey);
    check({tag, "_pending"}, int'(pending), ep);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit use_btn;
    int dx;
    int dy;
    bit do_frame;
    int exp_x;
    int exp_y;
    int exp_pend;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit got;
    int seen[4];
    int gcount;

    vecs[0] = '{0,   10,   -5, 1, 330, 235, 0};
    vecs[1] = '{1,  100,  100, 0, 330, 235, 1};
    vecs[2] = '{0,  127,  127, 1, 557, 462, 0};
    vecs[3] = '{1,  100,  100, 1, 636, 476, 0};
    vecs[4] = '{0, -128, -128, 1, 508, 348, 0};
    vecs[5] = '{0, -128, -128, 0, 508, 348, 1};
    vecs[6] = '{1, -128, -128, 1, 252,  92, 0};
    vecs[7] = '{0, -128, -128, 1, 124,   3, 0};
    vecs[8] = '{1, -128,    0, 1,   3,   3, 0};
    vecs[9] = '{0,    0,    0, 1,   3,   3, 0};

    // Reset state, then idle frames must change nothing.
    do_reset();
    check_out("reset", 320, 240, 0);
    for (int i = 0; i < 3; i++) begin
      frame_start = 1'b1;
      @(negedge clk);
      check("idle_frame_gnt", int'(gnt_bt | gnt_btn), 0);
      @(posedge clk);
      #1 frame_start = 1'b0;
      @(posedge clk);
      #1;
    end
    check_out("idle_frames", 320, 240, 0);

    // Directed vector table.
    do_reset();
    foreach (vecs[i]) begin
      move(vecs[i].use_btn, vecs[i].dx, vecs[i].dy);
      if (vecs[i].do_frame) frame();
      check_out($sformatf("vec%0d", i), vecs[i].exp_x, vecs[i].exp_y, vecs[i].exp_pend);
    end

    // Both requesters held: grants alternate starting with Bluetooth.
    do_reset();
    req_bt = 1'b1; req_btn = 1'b1;
    gcount = 0;
    for (int c = 0; c < 40 && gcount < 4; c++) begin
      @(negedge clk);
      if (gnt_bt) begin seen[gcount] = 0; gcount++; end
      else if (gnt_btn) begin seen[gcount] = 1; gcount++; end
      @(posedge clk);
      #1;
    end
    req_bt = 1'b0; req_btn = 1'b0;
    check("rr_grant_count", gcount, 4);
    for (int k = 0; k < 4; k++) check($sformatf("rr_order%0d", k), seen[k], k % 2);
    @(posedge clk);
    #1;

    // Clamp at the right/top edges, then bottom-left from (10,10).
    do_reset();
    move(0, 127, -128);
    move(0, 127, -107);
    move(1, 56, 0);
    move(1, 100, -100);
    frame();
    check_out("clamp_hi", 636, 3, 0);
    for (int k = 0; k < 4; k++) move(0, -128, (k == 0) ? 7 : 0);
    move(1, -114, 0);
    frame();
    check_out("at_10_10", 10, 10, 0);
    move(0, -128, -128);
    frame();
    check_out("clamp_lo", 3, 3, 0);

    // frame_start landing in the APPLY cycle is remembered and committed next IDLE.
    req_bt = 1'b1; bt_dx = 8'(20); bt_dy = 8'(30);
    wait_grant(1'b0, got);
    req_bt = 1'b0;
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_out("frame_in_apply", 23, 33, 0);

    // Request arriving with frame_start waits through COMMIT, then is granted.
    frame_start = 1'b1; req_bt = 1'b1; bt_dx = 8'(5); bt_dy = 8'(5);
    @(negedge clk);
    check("commit_first_gnt", int'(gnt_bt | gnt_btn), 0);
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(negedge clk);
    check("commit_cycle_gnt", int'(gnt_bt | gnt_btn), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_commit_gnt", int'(gnt_bt), 1);
    @(posedge clk);
    #1 req_bt = 1'b0;
    @(posedge clk);
    #1;
    frame();
    check_out("held_through_commit", 28, 38, 0);

    // Reset during APPLY discards the latched move.
    do_reset();
    req_bt = 1'b1; bt_dx = 8'(50); bt_dy = 8'(50);
    wait_grant(1'b0, got);
    req_bt = 1'b0;
    reset = 1'b0;
    #2;
    check("mid_apply_rst_x", int'(x_coordinate), 320);
    check("mid_apply_rst_pending", int'(pending), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    frame();
    check_out("after_mid_apply_rst", 320, 240, 0);

    // Small +-1 move: filtered only when the deadzone is built in.
    do_reset();
    move(0, 1, -1);
`ifdef CURSOR_SCHED_DEADZONE_EN
    check("small_move_pending", int'(pending), 0);
    frame();
    check_out("small_move", 320, 240, 0);
`else
    check("small_move_pending", int'(pending), 1);
    frame();
    check_out("small_move", 321, 239, 0);
`endif

    // Randomized moves against the reference model.
    do_reset();
    for (int t = 0; t < 80; t++) begin
      bit side;
      logic [7:0] rdx, rdy;
      side = 1'($urandom_range(0, 1));
      rdx  = 8'($urandom);
      rdy  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rdx = 8'($urandom_range(0, 2) - 1);
      move(side, sx8(rdx), sx8(rdy));
      @(negedge clk);
      check("rand_pending", int'(pending), md);
      @(posedge clk);
      #1;
      if ($urandom_range(0, 1) == 1) begin
        frame();
        check_out($sformatf("rand%0d", t), cx, cy, md);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
